// File: rtl/ahb_pkg.sv
// Shared AHB definitions used by the master mux and its burst tracker.
//   htrans_t  : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t  : burst type encoding (SINGLE .. INCR16)
//   burst_len : beat count of a fixed-length burst, 0 for SINGLE/INCR
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // SINGLE and undefined-length INCR have no beat count to track.
    function automatic logic [4:0] burst_len(hburst_t b);
        case (b)
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_mux_if.sv
// Bus bundle between the AHB masters/arbiter and the master mux.
//   Inputs to the mux : HMASTER, HREADY and the flattened per-master fields
//                       (master i occupies slice [i*W +: W]).
//   Outputs of the mux: muxed address/control, data-phase write data and
//                       owner, DATA_VALID and burst status flags.
// Modports: slave  - the mux view (it serves the masters)
//           master - the view of whatever drives the masters' requests
interface ahb_master_mux_if #(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [3:0]                    HMASTER;
    logic                          HREADY;
    logic [NUM_MASTERS*ADDR_W-1:0] HADDRx;
    logic [NUM_MASTERS*2-1:0]      HTRANSx;
    logic [NUM_MASTERS-1:0]        HWRITEx;
    logic [NUM_MASTERS*3-1:0]      HSIZEx;
    logic [NUM_MASTERS*3-1:0]      HBURSTx;
    logic [NUM_MASTERS*4-1:0]      HPROTx;
    logic [NUM_MASTERS*DATA_W-1:0] HWDATAx;

    logic [ADDR_W-1:0]             HADDR;
    logic [1:0]                    HTRANS;
    logic                          HWRITE;
    logic [2:0]                    HSIZE;
    logic [2:0]                    HBURST;
    logic [3:0]                    HPROT;
    logic [DATA_W-1:0]             HWDATA;
    logic [3:0]                    HMASTER_D;
    logic                          DATA_VALID;
    logic                          BURST_ACTIVE;
    logic                          BURST_EARLY_TERM;

    modport slave (
        input  HMASTER, HREADY, HADDRx, HTRANSx, HWRITEx, HSIZEx, HBURSTx, HPROTx, HWDATAx,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTER_D,
               DATA_VALID, BURST_ACTIVE, BURST_EARLY_TERM
    );

    modport master (
        output HMASTER, HREADY, HADDRx, HTRANSx, HWRITEx, HSIZEx, HBURSTx, HPROTx, HWDATAx,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTER_D,
               DATA_VALID, BURST_ACTIVE, BURST_EARLY_TERM
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// Fixed-length burst tracker on the muxed address phase.
//   clk, rst_n        : clock, asynchronous active-low reset
//   htrans, hburst    : muxed transfer type / burst type
//   hmaster, hready   : address-phase owner, bus ready
//   burst_active      : registered, high while a fixed burst is in progress
//   burst_early_term  : one-cycle pulse after a burst is cut short
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  htrans_t    htrans,
    input  hburst_t    hburst,
    input  logic [3:0] hmaster,
    input  logic       hready,
    output logic       burst_active,
    output logic       burst_early_term
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] beats_reg, beats_next;
    logic [3:0] owner_reg, owner_next;
    logic       term_reg,  term_next;
    logic [4:0] len;
    logic       starts_fixed;

    assign len          = burst_len(hburst);
    assign starts_fixed = (htrans == NONSEQ) && (len != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            beats_reg <= '0;
            owner_reg <= '0;
            term_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            beats_reg <= beats_next;
            owner_reg <= owner_next;
            term_reg  <= term_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beats_next = beats_reg;
        owner_next = owner_reg;
        term_next  = 1'b0;
        if (hready) begin
            case (state_reg)
                ST_IDLE: begin
                    if (starts_fixed) begin
                        state_next = ST_BURST;
                        beats_next = 4'(len - 5'd1);
                        owner_next = hmaster;
                    end
                end
                ST_BURST: begin
                    if (htrans == BUSY && hmaster == owner_reg) begin
                        // owner paused the burst: nothing moves
                    end else if (htrans == SEQ && hmaster == owner_reg) begin
                        beats_next = beats_reg - 4'd1;
                        if (beats_reg == 4'd1) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        // The cutting transfer may itself open a new fixed burst.
                        term_next = 1'b1;
                        if (starts_fixed) begin
                            state_next = ST_BURST;
                            beats_next = 4'(len - 5'd1);
                            owner_next = hmaster;
                        end else begin
                            state_next = ST_IDLE;
                            beats_next = '0;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign burst_active     = (state_reg == ST_BURST);
    assign burst_early_term = term_reg;

endmodule

// File: rtl/ahb_master_mux.sv
// AHB master-side multiplexer sitting after the arbiter.
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   bus (slave)   : per-master request fields in, muxed address/control,
//                   data-phase HWDATA/HMASTER_D/DATA_VALID and burst flags out
// Address/control are muxed combinationally from master[HMASTER]; the owner
// is registered into the data phase (only on HREADY) to steer HWDATA.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_master_mux_if.slave      bus
);

    logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
    logic [1:0]        trans_arr [NUM_MASTERS];
    logic [2:0]        size_arr  [NUM_MASTERS];
    logic [2:0]        burst_arr [NUM_MASTERS];
    logic [3:0]        prot_arr  [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.HADDRx[gi*ADDR_W +: ADDR_W];
        assign trans_arr[gi] = bus.HTRANSx[gi*2 +: 2];
        assign size_arr[gi]  = bus.HSIZEx[gi*3 +: 3];
        assign burst_arr[gi] = bus.HBURSTx[gi*3 +: 3];
        assign prot_arr[gi]  = bus.HPROTx[gi*4 +: 4];
        assign wdata_arr[gi] = bus.HWDATAx[gi*DATA_W +: DATA_W];
    end

    logic [ADDR_W-1:0] haddr_mux;
    htrans_t           htrans_mux;
    logic              hwrite_mux;
    logic [2:0]        hsize_mux;
    hburst_t           hburst_mux;
    logic [3:0]        hprot_mux;

    // An out-of-range HMASTER matches no entry and leaves the IDLE/zero defaults.
    always_comb begin
        haddr_mux  = '0;
        htrans_mux = IDLE;
        hwrite_mux = 1'b0;
        hsize_mux  = '0;
        hburst_mux = SINGLE;
        hprot_mux  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.HMASTER == 4'(i)) begin
                haddr_mux  = addr_arr[i];
                htrans_mux = htrans_t'(trans_arr[i]);
                hwrite_mux = bus.HWRITEx[i];
                hsize_mux  = size_arr[i];
                hburst_mux = hburst_t'(burst_arr[i]);
                hprot_mux  = prot_arr[i];
            end
        end
    end

    logic       xfer_real;
    logic [3:0] hmaster_d_reg;
    logic       valid_d_reg;
    logic       write_d_reg;

    assign xfer_real = (htrans_mux == NONSEQ) || (htrans_mux == SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmaster_d_reg <= '0;
            valid_d_reg   <= 1'b0;
            write_d_reg   <= 1'b0;
        end else if (bus.HREADY) begin
            hmaster_d_reg <= bus.HMASTER;
            valid_d_reg   <= xfer_real;
            write_d_reg   <= hwrite_mux & xfer_real;
        end
    end

    // Write data is forced to zero outside a real write data phase.
    logic [DATA_W-1:0] hwdata_mux;
    always_comb begin
        hwdata_mux = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (write_d_reg && hmaster_d_reg == 4'(i)) begin
                hwdata_mux = wdata_arr[i];
            end
        end
    end

    logic burst_active;
    logic burst_early_term;

    ahb_burst_tracker u_burst_tracker (
        .clk              (HCLK),
        .rst_n            (HRESETn),
        .htrans           (htrans_mux),
        .hburst           (hburst_mux),
        .hmaster          (bus.HMASTER),
        .hready           (bus.HREADY),
        .burst_active     (burst_active),
        .burst_early_term (burst_early_term)
    );

    assign bus.HADDR            = haddr_mux;
    assign bus.HTRANS           = htrans_mux;
    assign bus.HWRITE           = hwrite_mux;
    assign bus.HSIZE            = hsize_mux;
    assign bus.HBURST           = hburst_mux;
    assign bus.HPROT            = hprot_mux;
    assign bus.HWDATA           = hwdata_mux;
    assign bus.HMASTER_D        = hmaster_d_reg;
    assign bus.DATA_VALID       = valid_d_reg;
    assign bus.BURST_ACTIVE     = burst_active;
    assign bus.BURST_EARLY_TERM = burst_early_term;

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux with 8 masters, 32-bit address/data.
module tb_ahb_master_mux;

    localparam int NM = 8;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_INCR16 = 3'd7;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ahb_master_mux_if #(.NUM_MASTERS(NM), .ADDR_W(32), .DATA_W(32)) bus ();

    ahb_master_mux #(.NUM_MASTERS(NM), .ADDR_W(32), .DATA_W(32)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Put master m on the address phase with the given transfer.
    task automatic drive(input int m, input logic [1:0] trans, input logic [2:0] burst,
                         input logic wr);
        bus.HMASTER = 4'(m);
        if (m < NM) begin
            bus.HTRANSx[m*2 +: 2] = trans;
            bus.HBURSTx[m*3 +: 3] = burst;
            bus.HWRITEx[m]        = wr;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst_step(input string tag, input int m, input logic [1:0] trans,
                              input logic [2:0] burst, input logic exp_active,
                              input logic exp_term);
        drive(m, trans, burst, 1'b0);
        tick();
        $display("[%0t] %s: m=%0d trans=%0d burst=%0d active=%0b term=%0b", $time, tag, m,
                 trans, burst, bus.BURST_ACTIVE, bus.BURST_EARLY_TERM);
        check({tag, "_active"}, {31'd0, bus.BURST_ACTIVE}, {31'd0, exp_active});
        check({tag, "_term"}, {31'd0, bus.BURST_EARLY_TERM}, {31'd0, exp_term});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.HMASTER = 4'd0;
        bus.HREADY  = 1'b1;
        bus.HTRANSx = '0;
        bus.HWRITEx = '0;
        bus.HSIZEx  = '0;
        bus.HBURSTx = '0;
        bus.HPROTx  = '0;
        for (int i = 0; i < NM; i++) begin
            bus.HADDRx[i*32 +: 32]  = 32'h0001_0000 + 32'(i);
            bus.HWDATAx[i*32 +: 32] = 32'hCAFE_0000 + 32'(i);
        end
        bus.HADDRx[3*32 +: 32] = 32'h0000_1000;
        bus.HADDRx[5*32 +: 32] = 32'h0000_5000;
        bus.HSIZEx[3*3 +: 3]   = 3'd2;
        bus.HPROTx[3*4 +: 4]   = 4'h3;

        // Reset state
        #12;
        $display("[%0t] reset", $time);
        check("rst_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd0);
        check("rst_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
        check("rst_hwdata", bus.HWDATA, 32'd0);
        check("rst_burst_active", {31'd0, bus.BURST_ACTIVE}, 32'd0);
        check("rst_early_term", {31'd0, bus.BURST_EARLY_TERM}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single NONSEQ write from master 3
        drive(3, T_NONSEQ, B_SINGLE, 1'b1);
        #1;
        $display("[%0t] m3 NONSEQ write addr=%0h", $time, bus.HADDR);
        check("mux_haddr", bus.HADDR, 32'h0000_1000);
        check("mux_htrans", {30'd0, bus.HTRANS}, 32'd2);
        check("mux_hwrite", {31'd0, bus.HWRITE}, 32'd1);
        check("mux_hsize", {29'd0, bus.HSIZE}, 32'd2);
        check("mux_hprot", {28'd0, bus.HPROT}, 32'h3);
        tick();
        $display("[%0t] m3 data phase hwdata=%0h", $time, bus.HWDATA);
        check("dp_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd3);
        check("dp_data_valid", {31'd0, bus.DATA_VALID}, 32'd1);
        check("dp_hwdata", bus.HWDATA, 32'hCAFE_0003);
        check("dp_no_burst", {31'd0, bus.BURST_ACTIVE}, 32'd0);

        // Wait states while HMASTER moves to 5
        bus.HREADY = 1'b0;
        drive(5, T_IDLE, B_SINGLE, 1'b0);
        for (int w = 0; w < 2; w++) begin
            tick();
            $display("[%0t] wait %0d hmaster_d=%0d hwdata=%0h", $time, w, bus.HMASTER_D, bus.HWDATA);
            check("ws_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd3);
            check("ws_hwdata", bus.HWDATA, 32'hCAFE_0003);
        end
        check("ws_haddr_follows", bus.HADDR, 32'h0000_5000);
        bus.HREADY = 1'b1;
        tick();
        $display("[%0t] m5 IDLE accepted", $time);
        check("idle_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd5);
        check("idle_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
        check("idle_hwdata", bus.HWDATA, 32'd0);

        // INCR4 from master 2 with one BUSY
        burst_step("i4_b0", 2, T_NONSEQ, B_INCR4, 1'b1, 1'b0);
        burst_step("i4_b1", 2, T_SEQ,    B_INCR4, 1'b1, 1'b0);
        burst_step("i4_busy", 2, T_BUSY, B_INCR4, 1'b1, 1'b0);
        burst_step("i4_b2", 2, T_SEQ,    B_INCR4, 1'b1, 1'b0);
        burst_step("i4_b3", 2, T_SEQ,    B_INCR4, 1'b0, 1'b0);
        burst_step("i4_after", 2, T_IDLE, B_INCR4, 1'b0, 1'b0);

        // INCR8 from master 2 cut after beat 3 by master 7 WRAP4
        burst_step("i8_b0", 2, T_NONSEQ, B_INCR8, 1'b1, 1'b0);
        burst_step("i8_b1", 2, T_SEQ,    B_INCR8, 1'b1, 1'b0);
        burst_step("i8_b2", 2, T_SEQ,    B_INCR8, 1'b1, 1'b0);
        burst_step("w4_b0", 7, T_NONSEQ, B_WRAP4, 1'b1, 1'b1);
        burst_step("w4_b1", 7, T_SEQ,    B_WRAP4, 1'b1, 1'b0);
        burst_step("w4_b2", 7, T_SEQ,    B_WRAP4, 1'b1, 1'b0);
        burst_step("w4_b3", 7, T_SEQ,    B_WRAP4, 1'b0, 1'b0);
        burst_step("w4_after", 7, T_IDLE, B_WRAP4, 1'b0, 1'b0);

        // Out-of-range master index
        drive(12, T_NONSEQ, B_INCR4, 1'b1);
        #1;
        $display("[%0t] hmaster=12 htrans=%0d haddr=%0h", $time, bus.HTRANS, bus.HADDR);
        check("oor_htrans", {30'd0, bus.HTRANS}, 32'd0);
        check("oor_haddr", bus.HADDR, 32'd0);
        check("oor_hwrite", {31'd0, bus.HWRITE}, 32'd0);
        check("oor_hburst", {29'd0, bus.HBURST}, 32'd0);
        tick();
        check("oor_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd12);
        check("oor_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
        check("oor_no_burst", {31'd0, bus.BURST_ACTIVE}, 32'd0);

        // INCR16 from master 1, stall, then reset mid-burst
        burst_step("i16_b0", 1, T_NONSEQ, B_INCR16, 1'b1, 1'b0);
        burst_step("i16_b1", 1, T_SEQ,    B_INCR16, 1'b1, 1'b0);
        bus.HREADY = 1'b0;
        burst_step("i16_stall", 1, T_IDLE, B_INCR16, 1'b1, 1'b0);
        bus.HREADY = 1'b1;
        drive(1, T_SEQ, B_INCR16, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[%0t] reset mid INCR16", $time);
        check("mr_active", {31'd0, bus.BURST_ACTIVE}, 32'd0);
        check("mr_term", {31'd0, bus.BURST_EARLY_TERM}, 32'd0);
        check("mr_hmaster_d", {28'd0, bus.HMASTER_D}, 32'd0);
        check("mr_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
        tick();
        check("mr_term_hold", {31'd0, bus.BURST_EARLY_TERM}, 32'd0);
        rst_n = 1'b1;
        drive(1, T_IDLE, B_SINGLE, 1'b0);
        tick();
        $display("[%0t] after reset release", $time);
        check("mr_post_active", {31'd0, bus.BURST_ACTIVE}, 32'd0);
        check("mr_post_term", {31'd0, bus.BURST_EARLY_TERM}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_master_mux.md
Name: ahb_master_mux

Overview:
- Downstream of the AHB arbiter: consumes HMASTER and HREADY and routes the granted master's address/control onto the shared bus.
- Registers the address-phase owner into the data phase so that HWDATA comes from the correct master.
- Tracks fixed-length bursts and flags early termination caused by loss of grant or by an illegal transfer sequence.
- Feeds the decoder/slave side of the interconnect.

Parameters:
- NUM_MASTERS, 16, number of master ports. Maximum 16.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HMASTER  in  4  address-phase master index from the arbiter.
- HREADY  in  1  bus ready. Transfer accepted when 1.
- HADDRx  in  NUM_MASTERS*ADDR_W  flattened master addresses. Master i is at [i*ADDR_W +: ADDR_W].
- HTRANSx  in  NUM_MASTERS*2  flattened transfer types.
- HWRITEx  in  NUM_MASTERS  write flags.
- HSIZEx  in  NUM_MASTERS*3  transfer sizes.
- HBURSTx  in  NUM_MASTERS*3  burst types.
- HPROTx  in  NUM_MASTERS*4  protection.
- HWDATAx  in  NUM_MASTERS*DATA_W  write data.
- HADDR  out  ADDR_W  muxed address.
- HTRANS  out  2  muxed transfer type.
- HWRITE  out  1  muxed write flag.
- HSIZE  out  3  muxed size.
- HBURST  out  3  muxed burst type.
- HPROT  out  4  muxed protection.
- HWDATA  out  DATA_W  data-phase write data.
- HMASTER_D  out  4  data-phase master index.
- DATA_VALID  out  1  data phase carries a real (NONSEQ/SEQ) transfer.
- BURST_ACTIVE  out  1  fixed-length burst in progress.
- BURST_EARLY_TERM  out  1  one-cycle pulse on early burst termination.

Behaviour:
- Reset (HRESETn=0, asynchronous): HMASTER_D=0, DATA_VALID=0, data-phase write flag=0, BURST_ACTIVE=0, BURST_EARLY_TERM=0, beat counter=0, FSM=IDLE.
- HWDATA during reset is 0. The combinational outputs follow their inputs.
- Address mux is combinational with zero latency: each output equals master[HMASTER]'s field.
- If HMASTER >= NUM_MASTERS: HTRANS=IDLE, all other address/control outputs 0.
- Data-phase register updates on a rising HCLK with HREADY=1:
  - HMASTER_D <= HMASTER
  - DATA_VALID <= (HTRANS is NONSEQ or SEQ)
  - write flag <= HWRITE & that valid condition
- With HREADY=0, all data-phase registers hold. Wait states therefore keep the data-phase owner stable even when HMASTER changes.
- HWDATA = HWDATAx[HMASTER_D] when the registered write flag is 1, else 0.
- Burst FSM states are IDLE and BURST. It evaluates only on a rising edge with HREADY=1, on the muxed signals.
- Fixed burst lengths: INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16. SINGLE and INCR are not tracked.
- IDLE -> BURST when HTRANS=NONSEQ and HBURST is fixed. Latch beats_left=len-1 and burst_master=HMASTER.
- In BURST:
  - HTRANS=BUSY from burst_master: hold.
  - HTRANS=SEQ and HMASTER==burst_master: beats_left-1. Go to IDLE when this beat had beats_left==1.
  - Any other accepted transfer (IDLE, NONSEQ, or a different master) is an early termination.
- On early termination:
  - BURST_EARLY_TERM=1 for exactly the next cycle.
  - If the terminating transfer is a fixed-burst NONSEQ, re-enter BURST with fresh length and master in the same edge. Otherwise go to IDLE.
- HREADY=0 mid-burst: no state change and no pulse.
- BURST_ACTIVE = (state==BURST), registered.
- Reset asserted mid-burst: immediate return to IDLE, no termination pulse.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - hburst_t enum (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
  - function burst_len(hburst_t) returning 0 for untracked burst types
- One sub-module, ahb_burst_tracker, contains the FSM and beat counter. It takes muxed HTRANS/HBURST, HMASTER and HREADY, and outputs BURST_ACTIVE and BURST_EARLY_TERM.

Test Plan:
- Reset with all inputs X-free -> HMASTER_D=0, DATA_VALID=0, HWDATA=0, BURST_ACTIVE=0.
- HMASTER=3, master3 HADDR=0x1000, NONSEQ write, HWDATAx[3]=0xCAFE0003, HREADY=1 -> HADDR=0x1000 same cycle; next cycle HMASTER_D=3 and HWDATA=0xCAFE0003.
- Master 3 in data phase with HREADY=0 for 2 cycles while HMASTER switches to 5 -> HMASTER_D stays 3 and HWDATA stays 0xCAFE0003 until HREADY=1.
- Master 2 runs INCR4 (NONSEQ + 3 SEQ) with one BUSY inserted -> BURST_ACTIVE high 4 accepted beats; no BURST_EARLY_TERM pulse.
- Master 2 INCR8 interrupted after beat 3 by HMASTER=7 issuing NONSEQ WRAP4 -> BURST_EARLY_TERM pulses 1 cycle; BURST_ACTIVE stays 1; the new burst completes after 4 beats.
- HMASTER=12 with NUM_MASTERS=8 -> HTRANS=IDLE and HADDR=0. Assert HRESETn=0 mid-INCR16 -> BURST_ACTIVE=0 immediately, no pulse.
